// File: rtl/alu_pkg.sv
// alu_pkg -- encoding shared between the ALU control decoder and the
// execute unit, so both ends agree on op codes and FSM states.
//   alu_op_e      : 4-bit operation code (codes 1010-1111 are illegal)
//   exec_state_e  : execute-unit FSM states
//   is_shift_op() : true for SLL/SRL/SRA
package alu_pkg;

   localparam int ALU_OP_W = 4;
   localparam int SHAMT_W  = 5;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } exec_state_e;

   function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] code);
      return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_shift_step.sv
// alu_shift_step -- one iteration of the iterative shifter.
// Combinational: shifts i_value by i_amt (0..SHIFT_STEP) bits in the
// direction selected by i_kind. Anything other than SLL/SRA is treated as
// SRL; the caller only ever passes shift ops.
//   i_value : value being shifted
//   i_amt   : bits to shift this step, never larger than SHIFT_STEP
//   i_kind  : OP_SLL / OP_SRL / OP_SRA
//   o_value : shifted value
module alu_shift_step
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int SHIFT_STEP = 1,
   parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic [AMT_W-1:0] i_amt,
   input  alu_op_e          i_kind,
   output logic [WIDTH-1:0] o_value
);

   logic [WIDTH-1:0] w_sll;
   logic [WIDTH-1:0] w_srl;
   logic [WIDTH-1:0] w_sra;

   assign w_sll = i_value << i_amt;
   assign w_srl = i_value >> i_amt;
   assign w_sra = $signed(i_value) >>> i_amt;

   always_comb begin
      case (i_kind)
         OP_SLL:  o_value = w_sll;
         OP_SRA:  o_value = w_sra;
         default: o_value = w_srl;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage responder for the 4-bit ALU control code.
// Takes (op, a, b) over valid/ready, returns result + flags through a
// single-entry output register. Non-shift ops (and zero-amount shifts)
// complete in one cycle; other shifts iterate SHIFT_STEP bits per cycle.
//
// Build option: define ALU_BARREL_SHIFT_EN to replace the iterative shifter
// with a single-cycle combinational barrel shifter (SHIFT state unused,
// SHIFT_STEP ignored). Results are identical; only latency changes.
//
// Ports:
//   clk, rst                  : clock (rising edge), async active-high reset
//   in_valid/in_ready         : request handshake
//   in_aluctrl, in_a, in_b    : op code and operands (in_b[4:0] = shamt)
//   out_valid/out_ready       : result handshake
//   out_result                : result
//   out_zero                  : registered out_result == 0
//   out_illegal               : op code was undefined (result forced to 0)
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] in_aluctrl,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_result,
   output logic                out_zero,
   output logic                out_illegal
);

`ifdef ALU_BARREL_SHIFT_EN
   localparam bit BARREL_EN = 1'b1;
`else
   localparam bit BARREL_EN = 1'b0;
`endif
   localparam int AMT_W = $clog2(SHIFT_STEP + 1);

   exec_state_e      r_state, w_state_nxt;
   alu_op_e          r_op, w_op_nxt;
   logic [WIDTH-1:0] r_val, w_val_nxt;
   logic [SHAMT_W-1:0] r_rem, w_rem_nxt;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;

   logic             w_accept;
   logic             w_iter;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0] w_comb_res;
   logic             w_comb_ill;
   logic [WIDTH-1:0] w_sra;
   logic [WIDTH-1:0] w_step_out;
   logic [AMT_W-1:0] w_k;
   logic             w_load;
   logic [WIDTH-1:0] w_load_res;
   logic             w_load_ill;

   // A new request may enter only when idle and the output slot is free or
   // draining this same cycle.
   assign in_ready = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_shamt  = in_b[SHAMT_W-1:0];

   // Zero-amount shifts bypass the iterator: the result is just a.
   assign w_iter = !BARREL_EN && is_shift_op(in_aluctrl) && (w_shamt != '0);

   assign w_sra = $signed(in_a) >>> w_shamt;

   // Single-cycle datapath. Shift entries only matter when BARREL_EN or when
   // shamt == 0, in which case in_a is the right answer.
   always_comb begin
      w_comb_res = '0;
      w_comb_ill = 1'b0;
      case (in_aluctrl)
         OP_ADD:  w_comb_res = in_a + in_b;
         OP_SUB:  w_comb_res = in_a - in_b;
         OP_AND:  w_comb_res = in_a & in_b;
         OP_OR:   w_comb_res = in_a | in_b;
         OP_XOR:  w_comb_res = in_a ^ in_b;
         OP_SLL:  w_comb_res = BARREL_EN ? (in_a << w_shamt) : in_a;
         OP_SRL:  w_comb_res = BARREL_EN ? (in_a >> w_shamt) : in_a;
         OP_SRA:  w_comb_res = BARREL_EN ? w_sra : in_a;
         OP_SLT:  w_comb_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OP_SLTU: w_comb_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         default: w_comb_ill = 1'b1;
      endcase
   end

   // Bits to shift this iteration: min(remaining, SHIFT_STEP).
   assign w_k = (r_rem < SHAMT_W'(SHIFT_STEP)) ? r_rem[AMT_W-1:0] : AMT_W'(SHIFT_STEP);

`ifdef ALU_BARREL_SHIFT_EN
   assign w_step_out = r_val;
`else
   alu_shift_step #(
      .WIDTH      (WIDTH),
      .SHIFT_STEP (SHIFT_STEP),
      .AMT_W      (AMT_W)
   ) u_step (
      .i_value (r_val),
      .i_amt   (w_k),
      .i_kind  (r_op),
      .o_value (w_step_out)
   );
`endif

   // Next-state and output-register load control.
   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_val_nxt   = r_val;
      w_rem_nxt   = r_rem;
      w_load      = 1'b0;
      w_load_res  = w_comb_res;
      w_load_ill  = w_comb_ill;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_iter) begin
                  w_op_nxt    = alu_op_e'(in_aluctrl);
                  w_val_nxt   = in_a;
                  w_rem_nxt   = w_shamt;
                  w_state_nxt = SHIFT;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         SHIFT: begin
            w_val_nxt = w_step_out;
            w_rem_nxt = r_rem - SHAMT_W'(w_k);
            if (w_rem_nxt == '0) w_state_nxt = DONE;
         end
         DONE: begin
            // Output slot is guaranteed empty here: accept required it free
            // and nothing else can load it while shifting.
            w_load      = 1'b1;
            w_load_res  = r_val;
            w_load_ill  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op        <= OP_ADD;
         r_val       <= '0;
         r_rem       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_val   <= w_val_nxt;
         r_rem   <= w_rem_nxt;
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_load_res;
            r_zero      <= (w_load_res == '0);
            r_illegal   <= w_load_ill;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_result  = r_result;
   assign out_zero    = r_zero;
   assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a SHIFT_STEP=1 instance and a
// SHIFT_STEP=4 instance sharing clock, reset and operand buses.
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int W = 32;

`ifdef ALU_BARREL_SHIFT_EN
   localparam int LAT_SRA31_S1 = 0;
   localparam int LAT_SRA31_S4 = 0;
`else
   localparam int LAT_SRA31_S1 = 32;
   localparam int LAT_SRA31_S4 = 9;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal;
   logic [3:0]    in_aluctrl;
   logic [W-1:0]  in_a, in_b, out_result;
   logic          in_valid4, in_ready4, out_valid4, out_ready4, out_zero4, out_illegal4;
   logic [W-1:0]  out_result4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(W), .SHIFT_STEP(1)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_aluctrl(in_aluctrl),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_illegal(out_illegal)
   );

   alu_exec_unit #(.WIDTH(W), .SHIFT_STEP(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_aluctrl(in_aluctrl),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_result(out_result4),
      .out_zero(out_zero4), .out_illegal(out_illegal4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request on the step-1 unit for one edge.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      in_aluctrl = op;
      in_a       = a;
      in_b       = b;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0;
      out_ready = 1'b1; out_ready4 = 1'b1;
      in_aluctrl = 4'b0; in_a = '0; in_b = '0;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || out_result !== '0 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b r=%h z=%b i=%b want 0 0 0 0", out_valid, out_result, out_zero, out_illegal);
      end
      in_valid = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      in_valid = 1'b0;
      rst = 1'b0; #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_sub();
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin
         errors++;
         $display("FAIL add_wrap: got v=%b r=%h z=%b want v=1 r=80000000 z=0", out_valid, out_result, out_zero);
      end
      issue(OP_SUB, 32'd5, 32'd5);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1) begin
         errors++;
         $display("FAIL sub_zero: got v=%b r=%h z=%b want v=1 r=0 z=1", out_valid, out_result, out_zero);
      end
      issue(OP_SUB, 32'd0, 32'd1);
      checks++;
      if (out_result !== 32'hFFFF_FFFF || out_zero !== 1'b0) begin
         errors++;
         $display("FAIL sub_wrap: got r=%h z=%b want ffffffff 0", out_result, out_zero);
      end
      issue(OP_OR, 32'hA0A0_0000, 32'h0000_0505);
      checks++;
      if (out_result !== 32'hA0A0_0505) begin
         errors++;
         $display("FAIL or: got %h want a0a00505", out_result);
      end
      issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
      checks++;
      if (out_result !== 32'h0F00_0F00) begin
         errors++;
         $display("FAIL and: got %h want 0f000f00", out_result);
      end
   endtask

   task automatic test_compare();
      issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
      checks++;
      if (out_result !== 32'h1 || out_zero !== 1'b0) begin
         errors++;
         $display("FAIL slt_signed: got r=%h z=%b want 1 0", out_result, out_zero);
      end
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
      checks++;
      if (out_result !== 32'h0 || out_zero !== 1'b1) begin
         errors++;
         $display("FAIL sltu: got r=%h z=%b want 0 1", out_result, out_zero);
      end
      issue(OP_SLL, 32'h1234_5678, 32'h20);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h1234_5678) begin
         errors++;
         $display("FAIL sll_shamt0: got v=%b r=%h want v=1 r=12345678", out_valid, out_result);
      end
   endtask

   task automatic test_shift_latency();
      int lat1, lat4, ready_bad;
      logic [W-1:0] res1, res4;
      lat1 = -1; lat4 = -1; ready_bad = 0; res1 = '0; res4 = '0;
      in_aluctrl = OP_SRA; in_a = 32'h8000_0000; in_b = 32'd31;
      in_valid = 1'b1; in_valid4 = 1'b1;
      tick();
      in_valid = 1'b0; in_valid4 = 1'b0;
      // Operand changes mid-shift must be ignored.
      in_a = 32'h0000_0001; in_b = 32'd3; in_aluctrl = OP_SLL;
      for (int c = 0; c <= 40; c++) begin
         if (out_valid && lat1 < 0) begin lat1 = c; res1 = out_result; end
         if (out_valid4 && lat4 < 0) begin lat4 = c; res4 = out_result4; end
         if (lat1 < 0 && in_ready !== 1'b0) ready_bad++;
         if (lat1 >= 0 && lat4 >= 0) break;
         tick();
      end
      checks++;
      if (lat1 != LAT_SRA31_S1 || res1 !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sra31_step1: got lat=%0d r=%h want lat=%0d r=ffffffff", lat1, res1, LAT_SRA31_S1);
      end
      checks++;
      if (lat4 != LAT_SRA31_S4 || res4 !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sra31_step4: got lat=%0d r=%h want lat=%0d r=ffffffff", lat4, res4, LAT_SRA31_S4);
      end
      checks++;
      if (ready_bad != 0) begin
         errors++;
         $display("FAIL shift_in_ready_low: got %0d cycles with in_ready=1 want 0", ready_bad);
      end
      tick();
      // SRL on step-4 unit: shamt 6 -> 2 iterations (4 then 2).
      in_aluctrl = OP_SRL; in_a = 32'hF000_0000; in_b = 32'd6;
      in_valid4 = 1'b1; tick(); in_valid4 = 1'b0;
      lat4 = -1;
      for (int c = 0; c <= 10; c++) begin
         if (out_valid4) begin lat4 = c; res4 = out_result4; break; end
         tick();
      end
      checks++;
      if (res4 !== 32'h03C0_0000 || lat4 < 0) begin
         errors++;
         $display("FAIL srl6_step4: got lat=%0d r=%h want r=03c00000", lat4, res4);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int unstable;
      unstable = 0;
      out_ready = 1'b0;
      issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
      in_aluctrl = OP_ADD; in_a = 32'd2; in_b = 32'd3; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (out_valid !== 1'b1 || out_result !== 32'h0FF0_0FF0 || out_zero !== 1'b0 ||
             out_illegal !== 1'b0 || in_ready !== 1'b0) unstable++;
         tick();
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL xor_hold: got %0d unstable cycles want 0 (r=%h)", unstable, out_result);
      end
      out_ready = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_accept_ready: got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd5) begin
         errors++;
         $display("FAIL drain_accept_result: got v=%b r=%h want v=1 r=5", out_valid, out_result);
      end
   endtask

   task automatic test_illegal();
      issue(4'b1011, 32'hDEAD_BEEF, 32'h1234_5678);
      checks++;
      if (out_valid !== 1'b1 || out_result !== '0 || out_illegal !== 1'b1 || out_zero !== 1'b1) begin
         errors++;
         $display("FAIL illegal_1011: got v=%b r=%h i=%b z=%b want 1 0 1 1", out_valid, out_result, out_illegal, out_zero);
      end
      issue(OP_ADD, 32'd1, 32'd1);
      checks++;
      if (out_result !== 32'd2 || out_illegal !== 1'b0 || out_zero !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear: got r=%h i=%b z=%b want 2 0 0", out_result, out_illegal, out_zero);
      end
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      seen = 0;
      issue(OP_SLL, 32'h1, 32'd20);
      tick(); tick(); tick();
      rst = 1'b1; #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_shift_reset: got v=%b rdy=%b want 0 0", out_valid, in_ready);
      end
      tick();
      rst = 1'b0; #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_shift_idle: got in_ready=%b want 1", in_ready);
      end
      for (int c = 0; c < 25; c++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_shift_no_result: got %0d valid cycles want 0", seen);
      end
      issue(OP_ADD, 32'd10, 32'd20);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd30) begin
         errors++;
         $display("FAIL add_after_reset: got v=%b r=%h want v=1 r=1e", out_valid, out_result);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_compare();
      test_shift_latency();
      test_backpressure();
      test_illegal();
      test_reset_mid_shift();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage responder for the 4-bit ALU control code produced by the ALU control decoder.
- Accepts an operation (ALUctrl, operand A, operand B) over a valid/ready handshake, computes the result, and returns it with flags through a single-entry output register.
- Add/sub/logic/compare complete in one cycle. Shifts run iteratively to keep the barrel shifter off the critical path.
- Sits between the decode/issue stage and writeback/branch resolution.

Parameters:
- WIDTH, 32, operand/result width in bits; shift amount is always b[4:0].
- SHIFT_STEP, 1, maximum bits shifted per iteration; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- in_aluctrl  in  4  operation code
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (b[4:0] = shift amount)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_zero  out  1  out_result == 0
- out_illegal  out  1  code was not a defined operation

Behaviour:
- Op codes (shared package):
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 SLT (signed)
  - 1001 SLTU
  - 1010–1111 illegal.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU return 1 or 0, zero-extended.
  - SRA replicates a[WIDTH-1].
- Illegal codes: result 0, out_zero=1, out_illegal=1, latency 1.
- Reset: state=IDLE, out_valid=0, out_result=0, out_zero=0, out_illegal=0. in_ready=0 while rst is high. An in-progress shift is discarded.
- Handshake:
  - A transfer occurs when in_valid && in_ready (input) or out_valid && out_ready (output).
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so a result can drain and a new request be accepted in the same cycle.
  - While out_valid && !out_ready, out_result, out_zero and out_illegal hold stable.
- FSM:
  - IDLE: on accept of a non-shift op, or a shift with shamt==0, load the output register at the next edge (latency 1). out_valid=1; stay in IDLE.
  - IDLE: on accept of a shift with shamt>0, latch op, value=a and remaining=shamt. Go to SHIFT.
  - SHIFT: each cycle, shift value by k=min(remaining, SHIFT_STEP) and subtract k from remaining. When the new remaining==0, go to DONE.
  - DONE: out_register is written on entry; out_valid=1; go to IDLE on the same edge. DONE is a one-cycle transient.
  - Shift latency (accept edge to out_valid) = ceil(shamt/SHIFT_STEP)+1 cycles.
- in_* signals are sampled only on accept; changes during SHIFT are ignored.
- out_zero is registered with out_result, never computed combinationally from the output.
- rst asserted mid-shift: immediate return to IDLE, no result produced.

Optional Feature:
- ALU_BARREL_SHIFT_EN.
  - Defined: shifts complete in one cycle through a combinational barrel shifter. The SHIFT state is never entered. Every legal op has latency 1. SHIFT_STEP is ignored.
  - Undefined: iterative shifting as described in Behaviour.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg: alu_op_e enum (the ten codes above), ALU_OP_W=4, SHAMT_W=5, exec_state_e {IDLE, SHIFT, DONE}.
- Shared with the decoder so both ends use the same encoding.
- One sub-module: alu_shift_step. Combinational; shifts a value by 0..SHIFT_STEP according to a kind input (SLL/SRL/SRA). Instantiated once in the iterative path.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0x80000000, zero=0. SUB a=5, b=5 -> result=0, zero=1.
- SRA a=0x80000000, b=31, SHIFT_STEP=1 -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFF, in_ready=0 throughout. With SHIFT_STEP=4 -> 9 cycles. With ALU_BARREL_SHIFT_EN -> 1 cycle.
- SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0. SLL with b=0x20 (shamt 0) -> result=a, latency 1.
- Backpressure: out_ready=0 for 5 cycles after XOR result -> out_* stable, in_ready=0. Raise out_ready with in_valid=1 -> drain and accept in the same cycle.
- in_aluctrl=1011 -> result=0, out_illegal=1, zero=1. The next legal op clears out_illegal.
- Assert rst 3 cycles into SLL b=20 -> out_valid=0, state IDLE. After release, in_ready=1 and a new ADD completes normally.
